// File: rtl/timer_a_ctl.sv
// Timer_A control block: TAxCTL/TAxR/TAxIV registers, prescaler,
// counter modes, and interrupt vector arbitration for the CCMs.
module timer_a_ctl #(
    parameter logic [15:0] TAxCTL_OFFSET = 16'h0160,
    parameter logic [15:0] TAxR_OFFSET   = 16'h0170,
    parameter logic [15:0] TAxIV_OFFSET  = 16'h012E,
    parameter int          N_CCM         = 3
) (
    input  logic               MCLK,
    input  logic               reset,
    input  logic               TimerClock,
    input  logic [15:0]        MAB,
    input  logic [15:0]        MDBwrite,
    input  logic               MW,
    input  logic               BW,
    input  logic               MR,
    input  logic [15:0]        TACCR0,
    input  logic [N_CCM-2:0]   CCIFG,
    input  logic [N_CCM-2:0]   CCIE,
    output logic [15:0]        TAxRcurrent,
    output logic               EQU0,
    output logic [N_CCM-2:0]   CCIFGclr,
    output logic               IRQ,
    output logic [15:0]        MDBread
);

    localparam int          NC       = N_CCM - 1;
    localparam logic [15:0] CTL_MASK = 16'h03F3;

    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

    logic [15:0]   ctl_q, ctl_d;
    logic [15:0]   tar_q, tar_d;
    logic [2:0]    div_q, div_d;
    logic [2:0]    sync_q, sync_d;
    dir_e          dir_q, dir_d;
    logic          equ0_q, equ0_d;
    logic [NC-1:0] clr_q, clr_d;
    logic          ivrd_q, ivrd_d;

    logic          sel_ctl, sel_tar, sel_iv;
    logic          wr_ctl, wr_tar, rd_iv, iv_first;
    logic [15:0]   ctl_w, tar_w, iv;
    logic [NC-1:0] clr_sel;
    logic          iv_taifg, found;
    logic          tick, run, step_en, hw_ifg, taclr;
    logic [2:0]    div_max;

    function automatic logic [15:0] merge(input logic [15:0] old,
                                          input logic [15:0] wd,
                                          input logic        bw,
                                          input logic        hi);
        logic [15:0] r;
        if (!bw)     r = wd;
        else if (hi) r = {wd[7:0], old[7:0]};
        else         r = {old[15:8], wd[7:0]};
        return r;
    endfunction

    assign sel_ctl = ({MAB[15:1], 1'b0} == TAxCTL_OFFSET);
    assign sel_tar = ({MAB[15:1], 1'b0} == TAxR_OFFSET);
    assign sel_iv  = ({MAB[15:1], 1'b0} == TAxIV_OFFSET);
    assign wr_ctl  = MW & sel_ctl;
    assign wr_tar  = MW & sel_tar;
    assign rd_iv   = MR & sel_iv;

    // Lowest pending CCM wins; TAIFG only when no CCM is pending
    always_comb begin
        iv       = '0;
        clr_sel  = '0;
        iv_taifg = 1'b0;
        found    = 1'b0;
        for (int i = 0; i < NC; i++) begin
            if (!found && CCIFG[i] && CCIE[i]) begin
                iv         = 16'(2 * (i + 1));
                clr_sel[i] = 1'b1;
                found      = 1'b1;
            end
        end
        if (!found && ctl_q[0] && ctl_q[1]) begin
            iv       = 16'h000E;
            iv_taifg = 1'b1;
        end
    end

    always_comb begin
        sync_d   = {sync_q[1:0], TimerClock};
        tick     = sync_q[1] & ~sync_q[2];
        run      = (ctl_q[5:4] != 2'b00);
        div_max  = {&ctl_q[7:6], ctl_q[7], |ctl_q[7:6]};
        step_en  = tick & run & (div_q == div_max);
        ctl_w    = merge(ctl_q, MDBwrite, BW, MAB[0]);
        tar_w    = merge(tar_q, MDBwrite, BW, MAB[0]);
        taclr    = wr_ctl & ctl_w[2];
        iv_first = rd_iv & ~ivrd_q;
        ivrd_d   = rd_iv;

        tar_d  = tar_q;
        dir_d  = dir_q;
        div_d  = div_q;
        hw_ifg = 1'b0;

        if (tick && run)
            div_d = (div_q == div_max) ? 3'd0 : div_q + 3'd1;

        if (step_en) begin
            unique case (ctl_q[5:4])
                2'b01: begin
                    if (TACCR0 == 16'd0) begin
                        tar_d = '0;
                    end else if (tar_q >= TACCR0) begin
                        tar_d  = '0;
                        hw_ifg = 1'b1;
                    end else begin
                        tar_d = tar_q + 16'd1;
                    end
                end
                2'b10: begin
                    tar_d  = tar_q + 16'd1;
                    hw_ifg = (tar_q == 16'hFFFF);
                end
                2'b11: begin
                    if (TACCR0 == 16'd0) begin
                        tar_d = '0;
                        dir_d = UP;
                    end else if (dir_q == UP) begin
                        if (tar_q >= TACCR0) begin
                            dir_d = DOWN;
                            tar_d = tar_q - 16'd1;
                        end else begin
                            tar_d = tar_q + 16'd1;
                        end
                    end else if (tar_q <= 16'd1) begin
                        tar_d  = '0;
                        hw_ifg = (tar_q == 16'd1);
                        dir_d  = UP;
                    end else begin
                        tar_d = tar_q - 16'd1;
                    end
                end
                default: ;
            endcase
        end

        // A tick overridden by software must not raise TAIFG
        if (wr_tar) begin
            tar_d  = tar_w;
            hw_ifg = 1'b0;
        end
        if (taclr) begin
            tar_d  = '0;
            div_d  = '0;
            dir_d  = UP;
            hw_ifg = 1'b0;
        end

        ctl_d = ctl_q;
        if (wr_ctl)              ctl_d    = ctl_w & CTL_MASK;
        if (iv_first && iv_taifg) ctl_d[0] = 1'b0;
        if (hw_ifg)              ctl_d[0] = 1'b1;

        clr_d  = iv_first ? clr_sel : '0;
        equ0_d = (tar_d == TACCR0);
    end

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            ctl_q  <= '0;
            tar_q  <= '0;
            div_q  <= '0;
            sync_q <= '0;
            dir_q  <= UP;
            equ0_q <= 1'b0;
            clr_q  <= '0;
            ivrd_q <= 1'b0;
        end else begin
            ctl_q  <= ctl_d;
            tar_q  <= tar_d;
            div_q  <= div_d;
            sync_q <= sync_d;
            dir_q  <= dir_d;
            equ0_q <= equ0_d;
            clr_q  <= clr_d;
            ivrd_q <= ivrd_d;
        end
    end

    always_comb begin
        MDBread = '0;
        if (MR) begin
            if (sel_ctl)      MDBread = ctl_q;
            else if (sel_tar) MDBread = tar_q;
            else if (sel_iv)  MDBread = iv;
        end
    end

    assign TAxRcurrent = tar_q;
    assign EQU0        = equ0_q;
    assign CCIFGclr    = clr_q;
    assign IRQ         = (iv != 16'd0);

endmodule

// File: tb/tb_timer_a_ctl.sv
// Scoreboard bench for timer_a_ctl: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_timer_a_ctl;

    localparam logic [15:0] CTL = 16'h0160;
    localparam logic [15:0] TAR = 16'h0170;
    localparam logic [15:0] IV  = 16'h012E;

    localparam int S_TAR = 0;
    localparam int S_EQU = 1;
    localparam int S_IRQ = 2;
    localparam int S_RD  = 3;
    localparam int S_CLR = 4;

    localparam logic [15:0] UP_TAR [5] = '{1, 2, 3, 4, 0};
    localparam logic [15:0] UP_EQU [5] = '{0, 0, 0, 1, 0};
    localparam logic [15:0] UP_IRQ [5] = '{0, 0, 0, 0, 1};
    localparam logic [15:0] UD_TAR [7] = '{1, 2, 3, 2, 1, 0, 1};
    localparam logic [15:0] UD_EQU [7] = '{0, 0, 1, 0, 0, 0, 0};
    localparam logic [15:0] UD_IRQ [7] = '{0, 0, 0, 0, 0, 1, 1};

    logic        MCLK = 1'b0;
    logic        reset = 1'b0;
    logic        TimerClock = 1'b0;
    logic [15:0] MAB = '0;
    logic [15:0] MDBwrite = '0;
    logic        MW = 1'b0;
    logic        BW = 1'b0;
    logic        MR = 1'b0;
    logic [15:0] TACCR0 = 16'd4;
    logic [1:0]  CCIE = '0;
    logic [1:0]  ccifg_r = '0;
    logic [1:0]  ccifg_set = '0;
    logic [15:0] TAxRcurrent;
    logic        EQU0;
    logic [1:0]  CCIFGclr;
    logic        IRQ;
    logic [15:0] MDBread;

    timer_a_ctl #(.N_CCM(3)) dut (
        .MCLK(MCLK), .reset(reset), .TimerClock(TimerClock),
        .MAB(MAB), .MDBwrite(MDBwrite), .MW(MW), .BW(BW), .MR(MR),
        .TACCR0(TACCR0), .CCIFG(ccifg_r), .CCIE(CCIE),
        .TAxRcurrent(TAxRcurrent), .EQU0(EQU0), .CCIFGclr(CCIFGclr),
        .IRQ(IRQ), .MDBread(MDBread)
    );

    always #5 MCLK = ~MCLK;

    // CCM flag model: set by stimulus, cleared by the DUT's pulse
    always @(posedge MCLK) ccifg_r <= (ccifg_r | ccifg_set) & ~CCIFGclr;

    int cyc = 0;
    always @(posedge MCLK) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          sel;
        logic [15:0] exp;
        string       name;
    } sb_t;

    sb_t sbq[$];
    int  n_tests = 0;
    int  n_fail = 0;

    always @(negedge MCLK) begin
        sb_t         e;
        logic [15:0] act;
        while (sbq.size() != 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            case (e.sel)
                S_TAR:   act = TAxRcurrent;
                S_EQU:   act = {15'b0, EQU0};
                S_IRQ:   act = {15'b0, IRQ};
                S_RD:    act = MDBread;
                default: act = {14'b0, CCIFGclr};
            endcase
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL timeout: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    task automatic chk(input int sel, input logic [15:0] exp,
                       input string name);
        sbq.push_back('{due: cyc, sel: sel, exp: exp, name: name});
    endtask

    task automatic chk_now(input logic [15:0] act, input logic [15:0] exp,
                           input string name);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d,
                      input logic bw);
        MAB = a;
        MDBwrite = d;
        BW = bw;
        MW = 1'b1;
        step();
        MW = 1'b0;
        BW = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp,
                      input string name);
        MAB = a;
        MR = 1'b1;
        chk(S_RD, exp, name);
        step();
        MR = 1'b0;
    endtask

    // Leaves the synchronised tick active for the next MCLK edge
    task automatic tick_arm();
        TimerClock = 1'b1;
        step();
        TimerClock = 1'b0;
        step();
    endtask

    task automatic do_tick();
        tick_arm();
        step();
    endtask

    initial begin
        step();
        chk_now(TAxRcurrent, 16'h0000, "rst tar now");
        chk_now({15'b0, EQU0}, 16'h0000, "rst equ0 now");
        chk_now({15'b0, IRQ}, 16'h0000, "rst irq now");
        chk_now({14'b0, CCIFGclr}, 16'h0000, "rst clr now");
        chk(S_TAR, 0, "rst tar");
        chk(S_EQU, 0, "rst equ0");
        chk(S_IRQ, 0, "rst irq");
        chk(S_CLR, 0, "rst clr");
        step();
        reset = 1'b1;
        step();

        // up mode, period 4
        wr(CTL, 16'h0012, 1'b0);
        chk(S_TAR, 0, "up start");
        rd(CTL, 16'h0012, "ctl rd");
        for (int i = 0; i < 5; i++) begin
            do_tick();
            chk(S_TAR, UP_TAR[i], $sformatf("up tar %0d", i));
            chk(S_EQU, UP_EQU[i], $sformatf("up equ0 %0d", i));
            chk(S_IRQ, UP_IRQ[i], $sformatf("up irq %0d", i));
        end
        rd(IV, 16'h000E, "iv taifg");
        chk(S_IRQ, 0, "iv clr taifg");
        for (int i = 0; i < 3; i++) do_tick();
        chk(S_TAR, 3, "up tar 3");
        TACCR0 = 16'd2;
        do_tick();
        chk(S_TAR, 0, "ccr0 lowered");
        chk(S_IRQ, 1, "ccr0 lowered irq");
        rd(IV, 16'h000E, "iv lowered");
        TACCR0 = 16'd0;
        do_tick();
        do_tick();
        chk(S_TAR, 0, "ccr0 zero tar");
        chk(S_IRQ, 0, "ccr0 zero irq");
        chk(S_EQU, 1, "ccr0 zero equ0");

        // continuous, divide by 8
        wr(CTL, 16'h00E6, 1'b0);
        wr(TAR, 16'hFFFE, 1'b0);
        for (int i = 0; i < 7; i++) do_tick();
        chk(S_TAR, 16'hFFFE, "div8 hold");
        do_tick();
        chk(S_TAR, 16'hFFFF, "div8 step");
        chk(S_IRQ, 0, "cont no irq");
        for (int i = 0; i < 7; i++) do_tick();
        chk(S_TAR, 16'hFFFF, "div8 hold2");
        do_tick();
        chk(S_TAR, 0, "cont wrap");
        chk(S_IRQ, 1, "cont irq");
        rd(CTL, 16'h00E3, "ctl taifg");
        wr(CTL, 16'h00E2, 1'b0);
        chk(S_IRQ, 0, "sw clr taifg");
        wr(CTL + 16'd1, 16'h0003, 1'b1);
        rd(CTL, 16'h03E2, "bw odd");
        wr(CTL, 16'h0000, 1'b1);
        rd(CTL, 16'h0300, "bw even");
        wr(TAR, 16'h1234, 1'b0);
        do_tick();
        do_tick();
        chk(S_TAR, 16'h1234, "stop hold");

        // up/down, period 3
        TACCR0 = 16'd3;
        wr(CTL, 16'h0036, 1'b0);
        chk(S_TAR, 0, "ud clr");
        for (int i = 0; i < 7; i++) begin
            do_tick();
            chk(S_TAR, UD_TAR[i], $sformatf("ud tar %0d", i));
            chk(S_EQU, UD_EQU[i], $sformatf("ud equ0 %0d", i));
            chk(S_IRQ, UD_IRQ[i], $sformatf("ud irq %0d", i));
        end
        wr(CTL, 16'h0030, 1'b0);
        chk(S_IRQ, 0, "ud clr irq");

        // interrupt vector arbitration
        wr(CTL, 16'h0003, 1'b0);
        CCIE = 2'b11;
        ccifg_set = 2'b11;
        step();
        ccifg_set = 2'b00;
        chk(S_IRQ, 1, "irq pending");
        MAB = IV;
        MR = 1'b1;
        chk(S_RD, 16'h0002, "iv rd1");
        chk(S_CLR, 0, "clr idle");
        step();
        chk(S_CLR, 1, "clr k1");
        chk(S_RD, 16'h0002, "iv rd1 hold");
        step();
        chk(S_CLR, 0, "clr once");
        chk(S_RD, 16'h0004, "iv mr held");
        step();
        MR = 1'b0;
        step();
        MR = 1'b1;
        chk(S_RD, 16'h0004, "iv rd2");
        step();
        MR = 1'b0;
        chk(S_CLR, 2, "clr k2");
        step();
        MR = 1'b1;
        chk(S_RD, 16'h000E, "iv rd3");
        step();
        MR = 1'b0;
        chk(S_IRQ, 0, "irq drained");
        rd(IV, 16'h0000, "iv rd4");
        rd(CTL, 16'h0002, "ctl after iv");
        CCIE = 2'b00;

        // TACLR / TAR write against a same-edge tick
        wr(CTL, 16'h0034, 1'b0);
        for (int i = 0; i < 4; i++) do_tick();
        chk(S_TAR, 2, "ud down");
        wr(TAR, 16'h0010, 1'b0);
        rd(TAR, 16'h0010, "tar rd");
        tick_arm();
        wr(CTL, 16'h0034, 1'b0);
        chk(S_TAR, 0, "taclr vs tick");
        do_tick();
        chk(S_TAR, 1, "taclr dir up");
        tick_arm();
        wr(TAR, 16'h0100, 1'b0);
        chk(S_TAR, 16'h0100, "tar wr vs tick");

        // asynchronous reset mid-count
        wr(CTL, 16'h0023, 1'b0);
        do_tick();
        chk(S_TAR, 16'h0101, "pre rst tar");
        chk(S_IRQ, 1, "pre rst irq");
        @(posedge MCLK);
        #2;
        reset = 1'b0;
        chk(S_TAR, 0, "async tar");
        chk(S_IRQ, 0, "async irq");
        chk(S_EQU, 0, "async equ0");
        chk(S_CLR, 0, "async clr");
        chk(S_RD, 0, "async rd");
        step();
        step();
        reset = 1'b1;
        step();
        do_tick();
        do_tick();
        chk(S_TAR, 0, "post rst stop");
        chk(S_IRQ, 0, "post rst irq");
        chk(S_EQU, 0, "post rst equ0");
        chk(S_CLR, 0, "post rst clr");
        rd(CTL, 16'h0000, "post rst ctl");

        step();
        step();
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL expired: %0d expectations never checked",
                     sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
